// File: rtl/tpu_pkg.sv
// Shared types and default sizes for the systolic-array feeder.
package tpu_pkg;

  localparam int DEF_ARRAY_W = 2;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    SWITCH,
    STREAM,
    DRAIN
  } feeder_state_t;

  // Column counts above the physical array width are clamped to it.
  function automatic logic [15:0] sat_cols(input logic [15:0] cols, input int unsigned max_cols);
    if (32'(cols) > max_cols) return 16'(max_cols);
    return cols;
  endfunction

endpackage

// File: rtl/skew_line.sv
// DEPTH-stage data+valid shift register used to delay one array row by DEPTH cycles.
module skew_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [DATA_W-1:0] r_data  [DEPTH];
  logic              r_valid [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_data[k]  <= '0;
        r_valid[k] <= 1'b0;
      end
    end else begin
      r_data[0]  <= i_data;
      r_valid[0] <= i_valid;
      for (int k = 1; k < DEPTH; k++) begin
        r_data[k]  <= r_data[k-1];
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  assign o_data  = r_data[DEPTH-1];
  assign o_valid = r_valid[DEPTH-1];

endmodule

// File: rtl/sys_feeder.sv
// Feeds weights, the shadow-to-active switch and diagonally skewed activations into the systolic array.
// Optional SYS_FEEDER_STALL_CNT_EN adds stall_cnt_o (STREAM cycles without a_valid).
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// LOAD_W | accepting ARRAY_W weight rows, last one lands in row 0
// SWITCH | one cycle; schedules the switch pulse
// STREAM | accepting activation vectors into the skew lines
// DRAIN  | ARRAY_W cycles letting the skew lines empty, then done
module sys_feeder
  import tpu_pkg::*;
#(
  parameter int ARRAY_W = DEF_ARRAY_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [CNT_W-1:0]          cmd_n_act,
  input  logic [15:0]               cmd_cols,
  input  logic                      w_valid,
  output logic                      w_ready,
  input  logic [ARRAY_W*DATA_W-1:0] w_data,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [ARRAY_W*DATA_W-1:0] a_data,
  output logic [ARRAY_W*DATA_W-1:0] sys_weight_o,
  output logic [ARRAY_W-1:0]        sys_accept_w_o,
  output logic                      sys_switch_o,
  output logic [ARRAY_W*DATA_W-1:0] sys_data_o,
  output logic [ARRAY_W-1:0]        sys_valid_o,
  output logic [15:0]               col_size_o,
  output logic                      col_size_vld_o,
  output logic                      busy_o,
  output logic                      done_o
`ifdef SYS_FEEDER_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cnt_o
`endif
);

  localparam int              WC_W     = $clog2(ARRAY_W + 1);
  localparam logic [WC_W-1:0] LAST_IDX = WC_W'(ARRAY_W - 1);

  feeder_state_t    r_state;
  logic [CNT_W-1:0] r_act_left;
  logic [WC_W-1:0]  r_cnt;   // weight rows left in LOAD_W, flush cycles left in DRAIN
  logic             w_w_hs;
  logic             w_a_hs;

  assign w_w_hs = w_valid & w_ready;
  assign w_a_hs = a_valid & a_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_act_left     <= '0;
      r_cnt          <= '0;
      cmd_ready      <= 1'b1;
      w_ready        <= 1'b0;
      a_ready        <= 1'b0;
      sys_weight_o   <= '0;
      sys_accept_w_o <= '0;
      sys_switch_o   <= 1'b0;
      col_size_o     <= '0;
      col_size_vld_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      col_size_vld_o <= 1'b0;
      sys_switch_o   <= 1'b0;
      sys_accept_w_o <= '0;
      done_o         <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_state        <= LOAD_W;
            r_act_left     <= cmd_n_act;
            r_cnt          <= LAST_IDX;
            col_size_o     <= sat_cols(cmd_cols, ARRAY_W);
            col_size_vld_o <= 1'b1;
            cmd_ready      <= 1'b0;
            busy_o         <= 1'b1;
            w_ready        <= 1'b1;
          end
        end
        LOAD_W: begin
          if (w_w_hs) begin
            sys_weight_o   <= w_data;
            sys_accept_w_o <= '1;
            if (r_cnt == '0) begin
              r_state <= SWITCH;
              w_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt - WC_W'(1);
            end
          end
        end
        SWITCH: begin
          sys_switch_o <= 1'b1;
          r_cnt        <= LAST_IDX;
          if (r_act_left == '0) begin
            r_state <= DRAIN;
          end else begin
            r_state <= STREAM;
            a_ready <= 1'b1;
          end
        end
        STREAM: begin
          if (w_a_hs) begin
            r_act_left <= r_act_left - CNT_W'(1);
            if (r_act_left == CNT_W'(1)) begin
              r_state <= DRAIN;
              a_ready <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (r_cnt == '0) begin
            r_state   <= IDLE;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - WC_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SYS_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (r_state == IDLE && cmd_valid) begin
      stall_cnt_o <= '0;
    end else if (r_state == STREAM && !a_valid && stall_cnt_o != '1) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

  // Row r sits r+1 registers behind the accept so vectors enter the array on a diagonal.
  for (genvar r = 0; r < ARRAY_W; r++) begin : g_row
    logic [DATA_W-1:0] w_row_in;
    assign w_row_in = w_a_hs ? a_data[r*DATA_W +: DATA_W] : '0;

    skew_line #(
      .DEPTH  (r + 1),
      .DATA_W (DATA_W)
    ) u_skew (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_data  (w_row_in),
      .i_valid (w_a_hs),
      .o_data  (sys_data_o[r*DATA_W +: DATA_W]),
      .o_valid (sys_valid_o[r])
    );
  end

endmodule

// File: tb/tb_sys_feeder.sv
// Directed bench for sys_feeder (ARRAY_W=2, DATA_W=16); covers stall_cnt_o when SYS_FEEDER_STALL_CNT_EN is defined.
module tb_sys_feeder;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_n_act;
  logic [15:0] cmd_cols;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_data;
  logic [31:0] sys_weight;
  logic [1:0]  sys_accept_w;
  logic        sys_switch;
  logic [31:0] sys_data;
  logic [1:0]  sys_valid;
  logic [15:0] col_size;
  logic        col_size_vld;
  logic        busy;
  logic        done;
`ifdef SYS_FEEDER_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  sys_feeder #(.ARRAY_W(2), .DATA_W(16), .CNT_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_n_act      (cmd_n_act),
    .cmd_cols       (cmd_cols),
    .w_valid        (w_valid),
    .w_ready        (w_ready),
    .w_data         (w_data),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_data         (a_data),
    .sys_weight_o   (sys_weight),
    .sys_accept_w_o (sys_accept_w),
    .sys_switch_o   (sys_switch),
    .sys_data_o     (sys_data),
    .sys_valid_o    (sys_valid),
    .col_size_o     (col_size),
    .col_size_vld_o (col_size_vld),
    .busy_o         (busy),
    .done_o         (done)
`ifdef SYS_FEEDER_STALL_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        cr;
    logic        wr;
    logic        ar;
    logic        busy;
    logic        done;
    logic        cvld;
    logic [15:0] csize;
    logic        sw;
    logic [1:0]  acc;
    logic [31:0] wt;
    logic [1:0]  val;
    logic [31:0] dat;
  } outs_t;

  typedef struct {
    string       name;
    logic        cv;
    logic [15:0] n;
    logic [15:0] cols;
    logic        wv;
    logic [31:0] wd;
    logic        av;
    logic [31:0] ad;
    outs_t       exp;
  } vec_t;

  vec_t tbl[$];

  function automatic outs_t o(input logic cr, input logic wr, input logic ar, input logic bz,
                              input logic dn, input logic cvld, input logic [15:0] csize,
                              input logic sw, input logic [1:0] acc, input logic [31:0] wt,
                              input logic [1:0] val, input logic [31:0] dat);
    outs_t r;
    r.cr = cr; r.wr = wr; r.ar = ar; r.busy = bz; r.done = dn; r.cvld = cvld;
    r.csize = csize; r.sw = sw; r.acc = acc; r.wt = wt; r.val = val; r.dat = dat;
    return r;
  endfunction

  function automatic vec_t mk(input string nm, input logic cv, input logic [15:0] n,
                              input logic [15:0] cols, input logic wv, input logic [31:0] wd,
                              input logic av, input logic [31:0] ad, input outs_t e);
    vec_t v;
    v.name = nm; v.cv = cv; v.n = n; v.cols = cols; v.wv = wv; v.wd = wd;
    v.av = av; v.ad = ad; v.exp = e;
    return v;
  endfunction

  function automatic outs_t cur();
    return o(cmd_ready, w_ready, a_ready, busy, done, col_size_vld, col_size, sys_switch,
             sys_accept_w, sys_weight, sys_valid, sys_data);
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_n_act = '0; cmd_cols = '0;
    w_valid = 1'b0; w_data = '0; a_valid = 1'b0; a_data = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int done_seen;
    int valid_seen;
    int waited;

    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", cur(), o(1,0,0,0,0,0,16'd0,0,2'b00,32'h0,2'b00,32'h0));
    rst_n = 1'b1;

    // A: cols=2, weights {1,2},{3,4}, activations {5,6},{7,8}
    tbl.push_back(mk("A_cmd",  1,16'd2,16'd2, 0,32'h0,          0,32'h0,          o(0,1,0,1,0,1,16'd2,0,2'b00,32'h0,2'b00,32'h0)));
    tbl.push_back(mk("A_w0",   0,16'd0,16'd0, 1,32'h0002_0001, 0,32'h0,          o(0,1,0,1,0,0,16'd2,0,2'b11,32'h0002_0001,2'b00,32'h0)));
    tbl.push_back(mk("A_w1",   0,16'd0,16'd0, 1,32'h0004_0003, 0,32'h0,          o(0,0,0,1,0,0,16'd2,0,2'b11,32'h0004_0003,2'b00,32'h0)));
    tbl.push_back(mk("A_sw",   0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(0,0,1,1,0,0,16'd2,1,2'b00,32'h0004_0003,2'b00,32'h0)));
    tbl.push_back(mk("A_a0",   0,16'd0,16'd0, 0,32'h0,          1,32'h0006_0005, o(0,0,1,1,0,0,16'd2,0,2'b00,32'h0004_0003,2'b01,32'h0000_0005)));
    tbl.push_back(mk("A_a1",   0,16'd0,16'd0, 0,32'h0,          1,32'h0008_0007, o(0,0,0,1,0,0,16'd2,0,2'b00,32'h0004_0003,2'b11,32'h0006_0007)));
    tbl.push_back(mk("A_dr0",  0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(0,0,0,1,0,0,16'd2,0,2'b00,32'h0004_0003,2'b10,32'h0008_0000)));
    tbl.push_back(mk("A_done", 0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(1,0,0,0,1,0,16'd2,0,2'b00,32'h0004_0003,2'b00,32'h0)));
    tbl.push_back(mk("A_idle", 0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(1,0,0,0,0,0,16'd2,0,2'b00,32'h0004_0003,2'b00,32'h0)));
    // B: w stall, then n_act=3 with a 2-cycle activation gap
    tbl.push_back(mk("B_cmd",  1,16'd3,16'd1, 0,32'h0,          0,32'h0,          o(0,1,0,1,0,1,16'd1,0,2'b00,32'h0004_0003,2'b00,32'h0)));
    tbl.push_back(mk("B_wstl", 0,16'd0,16'd0, 0,32'h0000_0099, 0,32'h0,          o(0,1,0,1,0,0,16'd1,0,2'b00,32'h0004_0003,2'b00,32'h0)));
    tbl.push_back(mk("B_w0",   0,16'd0,16'd0, 1,32'h0000_0011, 0,32'h0,          o(0,1,0,1,0,0,16'd1,0,2'b11,32'h0000_0011,2'b00,32'h0)));
    tbl.push_back(mk("B_w1",   0,16'd0,16'd0, 1,32'h0022_0000, 0,32'h0,          o(0,0,0,1,0,0,16'd1,0,2'b11,32'h0022_0000,2'b00,32'h0)));
    tbl.push_back(mk("B_sw",   0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(0,0,1,1,0,0,16'd1,1,2'b00,32'h0022_0000,2'b00,32'h0)));
    tbl.push_back(mk("B_a0",   0,16'd0,16'd0, 0,32'h0,          1,32'h00B1_00A1, o(0,0,1,1,0,0,16'd1,0,2'b00,32'h0022_0000,2'b01,32'h0000_00A1)));
    tbl.push_back(mk("B_gap0", 0,16'd0,16'd0, 0,32'h0,          0,32'h00EE_00EE, o(0,0,1,1,0,0,16'd1,0,2'b00,32'h0022_0000,2'b10,32'h00B1_0000)));
    tbl.push_back(mk("B_gap1", 0,16'd0,16'd0, 0,32'h0,          0,32'h00EE_00EE, o(0,0,1,1,0,0,16'd1,0,2'b00,32'h0022_0000,2'b00,32'h0)));
    tbl.push_back(mk("B_a1",   0,16'd0,16'd0, 0,32'h0,          1,32'h00B2_00A2, o(0,0,1,1,0,0,16'd1,0,2'b00,32'h0022_0000,2'b01,32'h0000_00A2)));
    tbl.push_back(mk("B_a2",   0,16'd0,16'd0, 0,32'h0,          1,32'h00B3_00A3, o(0,0,0,1,0,0,16'd1,0,2'b00,32'h0022_0000,2'b11,32'h00B2_00A3)));
    tbl.push_back(mk("B_dr0",  0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(0,0,0,1,0,0,16'd1,0,2'b00,32'h0022_0000,2'b10,32'h00B3_0000)));
    tbl.push_back(mk("B_done", 0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(1,0,0,0,1,0,16'd1,0,2'b00,32'h0022_0000,2'b00,32'h0)));
    // C: cols=5 saturates, n_act=0, cmd_valid held while busy
    tbl.push_back(mk("C_cmd",  1,16'd0,16'd5, 0,32'h0,          0,32'h0,          o(0,1,0,1,0,1,16'd2,0,2'b00,32'h0022_0000,2'b00,32'h0)));
    tbl.push_back(mk("C_w0",   1,16'd7,16'd1, 1,32'h0000_0055, 0,32'h0,          o(0,1,0,1,0,0,16'd2,0,2'b11,32'h0000_0055,2'b00,32'h0)));
    tbl.push_back(mk("C_w1",   1,16'd7,16'd1, 1,32'h0066_0000, 0,32'h0,          o(0,0,0,1,0,0,16'd2,0,2'b11,32'h0066_0000,2'b00,32'h0)));
    tbl.push_back(mk("C_sw",   1,16'd7,16'd1, 0,32'h0,          1,32'h0000_00FF, o(0,0,0,1,0,0,16'd2,1,2'b00,32'h0066_0000,2'b00,32'h0)));
    tbl.push_back(mk("C_dr0",  0,16'd0,16'd0, 0,32'h0,          1,32'h0000_00FF, o(0,0,0,1,0,0,16'd2,0,2'b00,32'h0066_0000,2'b00,32'h0)));
    tbl.push_back(mk("C_done", 0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(1,0,0,0,1,0,16'd2,0,2'b00,32'h0066_0000,2'b00,32'h0)));
    tbl.push_back(mk("C_idle", 0,16'd0,16'd0, 0,32'h0,          0,32'h0,          o(1,0,0,0,0,0,16'd2,0,2'b00,32'h0066_0000,2'b00,32'h0)));

    foreach (tbl[i]) begin
      cmd_valid = tbl[i].cv; cmd_n_act = tbl[i].n; cmd_cols = tbl[i].cols;
      w_valid = tbl[i].wv; w_data = tbl[i].wd; a_valid = tbl[i].av; a_data = tbl[i].ad;
      cyc();
      chk(tbl[i].name, cur(), tbl[i].exp);
    end
    idle_inputs();

    // R: cols=0, then async reset mid-STREAM
    cmd_valid = 1'b1; cmd_n_act = 16'd4; cmd_cols = 16'd0;
    cyc();
    chk("R_cols0", {col_size_vld, col_size}, {1'b1, 16'd0});
    idle_inputs();
    w_valid = 1'b1; w_data = 32'h0002_0001;
    cyc();
    cyc();
    w_valid = 1'b0;
    cyc();
    a_valid = 1'b1; a_data = 32'h0077_0033;
    cyc();
    chk("R_pre_valid", {a_ready, sys_valid, sys_data}, {1'b1, 2'b01, 32'h0000_0033});
    #3;
    rst_n = 1'b0;
    #1;
    chk("R_reset_outs", cur(), o(1,0,0,0,0,0,16'd0,0,2'b00,32'h0,2'b00,32'h0));
    idle_inputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    valid_seen = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (done) done_seen++;
      if (sys_valid != 2'b00) valid_seen++;
    end
    chk("R_no_done", done_seen, 0);
    chk("R_skew_clear", valid_seen, 0);
    chk("R_idle", {cmd_ready, busy}, {1'b1, 1'b0});

`ifdef SYS_FEEDER_STALL_CNT_EN
    cmd_valid = 1'b1; cmd_n_act = 16'd2; cmd_cols = 16'd2;
    cyc();
    idle_inputs();
    w_valid = 1'b1; w_data = 32'h0001_0001;
    cyc();
    cyc();
    w_valid = 1'b0;
    cyc();
    repeat (3) cyc();
    a_valid = 1'b1; a_data = 32'h0002_0002;
    cyc();
    cyc();
    a_valid = 1'b0;
    waited = 0;
    while (!done && waited < 20) begin
      cyc();
      waited++;
    end
    chk("S_done_seen", done, 1'b1);
    chk("S_stall3", stall_cnt, 32'd3);
    cmd_valid = 1'b1; cmd_n_act = 16'd1; cmd_cols = 16'd1;
    cyc();
    idle_inputs();
    chk("S_clear", stall_cnt, 32'd0);
`else
    waited = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
